cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl_pkg.sv | 37 +++
 rtl/cp0_ctrl_timer.sv | 51 +++++
 rtl/cp0_ctrl.sv | 144 ++++++++++++++
 tb/tb_cp0_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register addresses, ExcCodes, Status/Cause bit positions, reset values.
package cp0_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;

    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_IV     = 23;
    localparam int CAUSE_WP     = 22;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_EXC_LO = 2;

    localparam logic [31:0] STATUS_RST = 32'h10400004;
    localparam logic [31:0] CONFIG_RST = 32'h00008000;

    // Only address-error exceptions capture a faulting virtual address.
    function automatic logic has_bad_addr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_ctrl_timer.sv
// Count/Compare timer with clock divider and sticky match interrupt.
module cp0_timer
    import cp0_ctrl_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

    logic [1:0] div_q;
    logic       tick;

    assign tick = (div_q == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            compare   <= '0;
            div_q     <= '0;
            timer_int <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div_q <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
                div_q <= '0;
            end else begin
                div_q <= div_q + 2'd1;
            end

            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (tick && !count_we && (count == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 control block: Status/Cause/EPC/BadVAddr, exception/ERET redirect, MFC0/MTC0.
// Optional timer (Count/Compare) is built when CP0_TIMER_EN is defined.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  in_delayslot_i,
    input  logic [31:0]           bad_addr_i,
    input  logic                  eret_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic                  flush_o,
    output logic [31:0]           target_pc_o,
    output logic                  timer_int_o
);

    logic [31:0] status_q, epc_q, badvaddr_q;
    logic [31:0] count, compare;
    logic        bd_q, iv_q, wp_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q, int_ext;
    logic        mtc0;

    // Exceptions and ERET pre-empt any same-cycle MTC0.
    assign mtc0 = we_i && !exc_valid_i && !eret_i;

`ifdef CP0_TIMER_EN
    logic count_we, compare_we;

    assign count_we   = mtc0 && (waddr_i == CP0_COUNT);
    assign compare_we = mtc0 && (waddr_i == CP0_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (data_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int_o)
    );
`else
    assign count       = '0;
    assign compare     = '0;
    assign timer_int_o = 1'b0;
`endif

    // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
    always_comb begin
        int_ext = '0;
        for (int i = 0; i < HW_INT_NUM; i++) int_ext[i] = int_i[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            iv_q       <= 1'b0;
            wp_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            ip_hw_q <= int_ext;
            if (exc_valid_i) begin
                // A nested exception keeps the original return point.
                if (!status_q[STATUS_EXL]) begin
                    epc_q <= in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                    bd_q  <= in_delayslot_i;
                end
                status_q[STATUS_EXL] <= 1'b1;
                exc_code_q           <= exc_code_i;
                if (has_bad_addr(exc_code_i)) badvaddr_q <= bad_addr_i;
            end else if (eret_i) begin
                status_q[STATUS_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    CP0_STATUS: status_q <= data_i;
                    CP0_CAUSE: begin
                        iv_q    <= data_i[CAUSE_IV];
                        wp_q    <= data_i[CAUSE_WP];
                        ip_sw_q <= data_i[CAUSE_IP_LO +: 2];
                    end
                    CP0_EPC: epc_q <= data_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cause_o                      = '0;
        cause_o[CAUSE_BD]            = bd_q;
        cause_o[CAUSE_TI]            = timer_int_o;
        cause_o[CAUSE_IV]            = iv_q;
        cause_o[CAUSE_WP]            = wp_q;
        cause_o[CAUSE_IP_LO +: 8]    = {ip_hw_q[5] | timer_int_o, ip_hw_q[4:0], ip_sw_q};
        cause_o[CAUSE_EXC_LO +: 5]   = exc_code_q;
    end

    assign status_o  = status_q;
    assign epc_o     = epc_q;
    assign int_req_o = status_q[STATUS_IE] && !status_q[STATUS_EXL] &&
                       (|(cause_o[CAUSE_IP_LO +: 8] & status_q[STATUS_IM_LO +: 8]));

    assign flush_o     = rst && (exc_valid_i || eret_i);
    assign target_pc_o = exc_valid_i ? EXC_VEC : epc_q;

    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_q;
            CP0_COUNT:    data_o = count;
            CP0_COMPARE:  data_o = compare;
            CP0_STATUS:   data_o = status_q;
            CP0_CAUSE:    data_o = cause_o;
            CP0_EPC:      data_o = epc_q;
            CP0_PRID:     data_o = PRID_VAL;
            CP0_CONFIG:   data_o = CONFIG_RST;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed tables, corner sequences, random vs. a behavioural model.
module tb_cp0_ctrl;
    localparam int COUNT_DIV = 2;
    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam logic [31:0] PRID    = 32'h004C0102;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0;
    logic        we_i = 0, exc_valid_i = 0, in_delayslot_i = 0, eret_i = 0;
    logic [4:0]  waddr_i = 0, raddr_i = 0, exc_code_i = 0;
    logic [31:0] data_i = 0, exc_pc_i = 0, bad_addr_i = 0;
    logic [5:0]  int_i = 0;
    logic [31:0] data_o, status_o, cause_o, epc_o, target_pc_o;
    logic        int_req_o, flush_o, timer_int_o;

    int n_checks = 0, n_fail = 0;

    cp0_ctrl #(.HW_INT_NUM(6), .COUNT_DIV(COUNT_DIV), .EXC_VEC(EXC_VEC), .PRID_VAL(PRID)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i), .data_i(data_i),
        .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .eret_i(eret_i),
        .data_o(data_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .int_req_o(int_req_o), .flush_o(flush_o), .target_pc_o(target_pc_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Architectural model: registers as plain variables, updated once per clock edge.
    logic [31:0] m_count, m_compare, m_status, m_epc, m_badv;
    logic        m_ti, m_bd, m_iv, m_wp;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    int          m_cycles_since;

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_status = 32'h10400004; m_epc = 0; m_badv = 0;
        m_ti = 0; m_bd = 0; m_iv = 0; m_wp = 0; m_code = 0; m_ipsw = 0; m_iphw = 0;
        m_cycles_since = 0;
    endtask

    task automatic model_step();
        bit sw;
        sw = we_i && !exc_valid_i && !eret_i;
        if (TIMER) begin
            if (sw && waddr_i == 5'd9) begin
                m_count = data_i;
                m_cycles_since = 0;
            end else if (m_cycles_since == COUNT_DIV - 1) begin
                if (m_count == m_compare) m_ti = 1;
                m_count = m_count + 1;
                m_cycles_since = 0;
            end else begin
                m_cycles_since++;
            end
            if (sw && waddr_i == 5'd11) begin
                m_compare = data_i;
                m_ti = 0;
            end
        end
        m_iphw = int_i;
        if (exc_valid_i) begin
            if (!m_status[1]) begin
                m_epc = in_delayslot_i ? exc_pc_i - 4 : exc_pc_i;
                m_bd  = in_delayslot_i;
            end
            m_status[1] = 1;
            m_code = exc_code_i;
            if (exc_code_i == 4 || exc_code_i == 5) m_badv = bad_addr_i;
        end else if (eret_i) begin
            m_status[1] = 0;
        end else if (sw) begin
            if (waddr_i == 5'd12) m_status = data_i;
            if (waddr_i == 5'd13) begin
                m_iv = data_i[23]; m_wp = data_i[22]; m_ipsw = data_i[9:8];
            end
            if (waddr_i == 5'd14) m_epc = data_i;
        end
    endtask

    function automatic logic [31:0] model_cause();
        logic [7:0] ip;
        ip = {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
        return {m_bd, m_ti, 6'b0, m_iv, m_wp, 6'b0, ip, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return model_cause();
            5'd14: return m_epc;
            5'd15: return PRID;
            5'd16: return 32'h00008000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] ip;
        ip = model_cause() >> 8;
        check({tag, ".status"}, status_o, m_status);
        check({tag, ".cause"},  cause_o,  model_cause());
        check({tag, ".epc"},    epc_o,    m_epc);
        check({tag, ".data"},   data_o,   model_read(raddr_i));
        check({tag, ".timer"},  {31'b0, timer_int_o}, {31'b0, m_ti});
        check({tag, ".intreq"}, {31'b0, int_req_o},
              {31'b0, m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 0)});
        check({tag, ".flush"},  {31'b0, flush_o}, {31'b0, exc_valid_i || eret_i});
        check({tag, ".target"}, target_pc_o, exc_valid_i ? EXC_VEC : m_epc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1; waddr_i = a; data_i = d;
        tick();
        we_i = 0;
        #1;
    endtask

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];
    logic [31:0] exp38[5];
    logic [4:0]  addr_pool[9];
    bit          seen;

    initial begin
        vecs[0] = '{5'd12, 32'h0000FF00, 5'd12, 32'h0000FF00};
        vecs[1] = '{5'd13, 32'hFFFFFFFF, 5'd13, 32'h00C00300};
        vecs[2] = '{5'd13, 32'h00000000, 5'd13, 32'h00000000};
        vecs[3] = '{5'd14, 32'h12345678, 5'd14, 32'h12345678};
        vecs[4] = '{5'd15, 32'hFFFFFFFF, 5'd15, PRID};
        vecs[5] = '{5'd16, 32'h00000000, 5'd16, 32'h00008000};
        vecs[6] = '{5'd8,  32'hFFFFFFFF, 5'd8,  32'h00000000};
        vecs[7] = '{5'd3,  32'hFFFFFFFF, 5'd3,  32'h00000000};
        vecs[8] = '{5'd11, 32'hFFFFFFFF, 5'd11, TIMER ? 32'hFFFFFFFF : 32'h0};
        exp38 = '{0, 0, TIMER ? 1 : 0, TIMER ? 1 : 0, TIMER ? 2 : 0};
        addr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};

        // Reset holds state and masks an in-flight exception/ERET.
        model_reset();
        exc_valid_i = 1; eret_i = 1; raddr_i = 5'd12;
        repeat (3) @(negedge clk);
        #1;
        check("rst.flush",  {31'b0, flush_o}, 0);
        check("rst.status", status_o, 32'h10400004);
        check("rst.cause",  cause_o, 0);
        check("rst.epc",    epc_o, 0);
        check("rst.timer",  {31'b0, timer_int_o}, 0);
        raddr_i = 5'd16; #1;
        check("rst.config", data_o, 32'h00008000);
        @(negedge clk);
        exc_valid_i = 0; eret_i = 0; raddr_i = 5'd9;
        rst = 1;
        #1;

        // Count advances every COUNT_DIV cycles from release.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("count_seq%0d", i), data_o, exp38[i]);
            if (i < 4) begin tick(); #1; end
        end

        // Compare match sets a sticky timer interrupt; a Compare write clears it.
        mtc0(5'd11, 32'd5);
        check("cmp.clear", {31'b0, timer_int_o}, 0);
`ifdef CP0_TIMER_EN
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (data_o == 32'd7) seen = 1;
            else begin tick(); #1; end
        end
        check("cmp.wait_count7", {31'b0, seen}, 1);
`endif
        check("cmp.sticky", {31'b0, timer_int_o}, {31'b0, TIMER});
        check("cmp.ti",     {31'b0, cause_o[30]}, {31'b0, TIMER});
        mtc0(5'd11, 32'h100);
        check("cmp.cleared", {31'b0, timer_int_o}, 0);

        // Count wraps from all-ones to zero.
        mtc0(5'd9, 32'hFFFFFFFF);
        tick(); #1;
        check("wrap.pre",  data_o, TIMER ? 32'hFFFFFFFF : 32'h0);
        tick(); #1;
        check("wrap.post", data_o, 32'h0);
        mtc0(5'd11, 32'hFFFFFFFF);

        // Write / read-back table.
        foreach (vecs[i]) begin
            raddr_i = vecs[i].raddr;
            mtc0(vecs[i].waddr, vecs[i].wdata);
            check($sformatf("tbl%0d", i), data_o, vecs[i].exp);
        end

        // Hardware interrupt reaches Cause.IP2 and int_req; EXL masks it.
        int_i = 6'b000001;
        mtc0(5'd12, 32'h0000FF01);
        check("int.ip2",    {31'b0, cause_o[10]}, 1);
        check("int.req",    {31'b0, int_req_o}, 1);
        mtc0(5'd12, 32'h0000FF03);
        check("int.exl_mask", {31'b0, int_req_o}, 0);
        int_i = 0;
        mtc0(5'd12, 32'h0000FF00);

        // First exception from a delay slot.
        exc_valid_i = 1; exc_code_i = 5'd4; exc_pc_i = 32'h80000010;
        in_delayslot_i = 1; bad_addr_i = 32'h1233; raddr_i = 5'd8;
        #1;
        check("exc1.flush",  {31'b0, flush_o}, 1);
        check("exc1.target", target_pc_o, EXC_VEC);
        tick(); exc_valid_i = 0; #1;
        check("exc1.epc",  epc_o, 32'h8000000C);
        check("exc1.bd",   {31'b0, cause_o[31]}, 1);
        check("exc1.code", {27'b0, cause_o[6:2]}, 4);
        check("exc1.badv", data_o, 32'h1233);
        check("exc1.exl",  {31'b0, status_o[1]}, 1);

        // Nested exception keeps EPC/BD; then ERET returns to EPC.
        exc_valid_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h80000100;
        in_delayslot_i = 0; bad_addr_i = 32'hDEAD;
        tick(); exc_valid_i = 0; #1;
        check("exc2.epc",  epc_o, 32'h8000000C);
        check("exc2.bd",   {31'b0, cause_o[31]}, 1);
        check("exc2.code", {27'b0, cause_o[6:2]}, 8);
        check("exc2.badv", data_o, 32'h1233);
        eret_i = 1; #1;
        check("eret.flush",  {31'b0, flush_o}, 1);
        check("eret.target", target_pc_o, 32'h8000000C);
        tick(); eret_i = 0; #1;
        check("eret.exl", {31'b0, status_o[1]}, 0);

        // Exception + ERET + MTC0 EPC together: only the exception takes effect.
        exc_valid_i = 1; eret_i = 1; exc_code_i = 5'd0; exc_pc_i = 32'h80000200;
        we_i = 1; waddr_i = 5'd14; data_i = 32'h55555555;
        #1;
        check("prio.target", target_pc_o, EXC_VEC);
        tick(); exc_valid_i = 0; eret_i = 0; we_i = 0; #1;
        check("prio.epc", epc_o, 32'h80000200);
        check("prio.exl", {31'b0, status_o[1]}, 1);

        // MFC0 sees the old value during the MTC0 cycle.
        raddr_i = 5'd14; we_i = 1; waddr_i = 5'd14; data_i = 32'h11112222; #1;
        check("nobypass.old", data_o, 32'h80000200);
        tick(); we_i = 0; #1;
        check("nobypass.new", data_o, 32'h11112222);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we_i           = ($urandom_range(0, 2) == 0);
            waddr_i        = addr_pool[$urandom_range(0, 8)];
            raddr_i        = addr_pool[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: data_i = m_count + $urandom_range(0, 3);
                1: data_i = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: data_i = $urandom;
            endcase
            int_i          = 6'($urandom);
            exc_valid_i    = ($urandom_range(0, 15) == 0);
            eret_i         = ($urandom_range(0, 11) == 0);
            exc_code_i     = ($urandom_range(0, 1) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
            exc_pc_i       = $urandom & 32'hFFFFFFFC;
            in_delayslot_i = 1'($urandom);
            bad_addr_i     = $urandom;
            #1;
            compare_all($sformatf("rnd%0d", i));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
